ddr3_cmd_decoder: RTL and testbench

DDR3_CMD_DECODER -- requirements
Module: ddr3_cmd_decoder

---
 rtl/ddr3_dec_pkg.sv | 61 ++++++
 rtl/ddr3_bank_timer.sv | 45 ++++
 rtl/ddr3_cmd_decoder.sv | 164 ++++++++++++++++
 tb/tb_ddr3_cmd_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_dec_pkg.sv
// Shared types for the DDR3 command decoder: decoded command, violation cause,
// raw {cs_n,ras_n,cas_n,we_n} pin encodings and the CAS-latency decode helper.
package ddr3_dec_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_REF,
    CMD_MRS,
    CMD_ZQ
  } cmd_t;

  // Ordered so that NONE is the reset value; priority is resolved in the decoder.
  typedef enum logic [3:0] {
    VIOL_NONE,
    VIOL_ACT_OPEN,
    VIOL_RW_CLOSED,
    VIOL_REF_OPEN,
    VIOL_BAD_MRS,
    VIOL_TRAS,
    VIOL_TRCD,
    VIOL_TRP,
    VIOL_TRFC
  } viol_t;

  localparam logic [3:0] PIN_MRS = 4'b0000;
  localparam logic [3:0] PIN_REF = 4'b0001;
  localparam logic [3:0] PIN_PRE = 4'b0010;
  localparam logic [3:0] PIN_ACT = 4'b0011;
  localparam logic [3:0] PIN_WR  = 4'b0100;
  localparam logic [3:0] PIN_RD  = 4'b0101;
  localparam logic [3:0] PIN_ZQ  = 4'b0110;
  localparam logic [3:0] PIN_NOP = 4'b0111;

  function automatic cmd_t decode_pins(input logic cke, input logic [3:0] pins);
    cmd_t c;
    c = CMD_NOP;
    if (cke) begin
      case (pins)
        PIN_ACT: c = CMD_ACT;
        PIN_RD:  c = CMD_RD;
        PIN_WR:  c = CMD_WR;
        PIN_PRE: c = CMD_PRE;
        PIN_REF: c = CMD_REF;
        PIN_MRS: c = CMD_MRS;
        PIN_ZQ:  c = CMD_ZQ;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

  // Only the mr0[2]=0 encodings map to a CAS latency; everything else reads as 0.
  function automatic logic [4:0] cl_decode(input logic a2, input logic [2:0] cl_bits);
    return a2 ? 5'd0 : 5'd4 + {2'b00, cl_bits};
  endfunction

endpackage

// File: rtl/ddr3_bank_timer.sv
// One bank's tRCD / tRP / tRAS down-counters; each busy flag is high while the
// corresponding minimum spacing has not yet elapsed.
module ddr3_bank_timer
  import ddr3_dec_pkg::*;
#(
  parameter int T_RCD = 11,
  parameter int T_RP  = 11,
  parameter int T_RAS = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic act,
  input  logic pre,
  output logic rcd_busy,
  output logic rp_busy,
  output logic ras_busy
);

  localparam int TMAX = (T_RAS > T_RCD) ? ((T_RAS > T_RP) ? T_RAS : T_RP)
                                        : ((T_RCD > T_RP) ? T_RCD : T_RP);
  localparam int CW = $clog2(TMAX + 1);

  logic [CW-1:0] rcd_cnt, rp_cnt, ras_cnt;

  // Loading T-1 on the command edge makes a command exactly T cycles later legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcd_cnt <= '0;
      rp_cnt  <= '0;
      ras_cnt <= '0;
    end else begin
      if (act)                 rcd_cnt <= CW'(T_RCD - 1);
      else if (rcd_cnt != '0)  rcd_cnt <= rcd_cnt - CW'(1);
      if (act)                 ras_cnt <= CW'(T_RAS - 1);
      else if (ras_cnt != '0)  ras_cnt <= ras_cnt - CW'(1);
      if (pre)                 rp_cnt  <= CW'(T_RP - 1);
      else if (rp_cnt != '0)   rp_cnt  <= rp_cnt - CW'(1);
    end
  end

  assign rcd_busy = (rcd_cnt != '0);
  assign rp_busy  = (rp_cnt != '0);
  assign ras_busy = (ras_cnt != '0);

endmodule

// File: rtl/ddr3_cmd_decoder.sv
// DDR3 command decoder: registers decoded commands, tracks open banks/rows and mode
// registers, flags protocol violations. DDR3_TIMING_CHECK_EN adds tRCD/tRP/tRAS/tRFC checks.
module ddr3_cmd_decoder
  import ddr3_dec_pkg::*;
#(
  parameter int BA_W   = 3,
  parameter int ADDR_W = 14,
  parameter int T_RCD  = 11,
  parameter int T_RP   = 11,
  parameter int T_RAS  = 28,
  parameter int T_RFC  = 128
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cke,
  input  logic                                cs_n,
  input  logic                                ras_n,
  input  logic                                cas_n,
  input  logic                                we_n,
  input  logic [BA_W-1:0]                     ba,
  input  logic [ADDR_W-1:0]                   addr,
  output logic                                cmd_valid,
  output cmd_t                                cmd_type,
  output logic [BA_W-1:0]                     cmd_ba,
  output logic [ADDR_W-1:0]                   cmd_addr,
  output logic [2**BA_W-1:0]                  bank_open,
  output logic [2**BA_W-1:0][ADDR_W-1:0]      open_row,
  output logic [ADDR_W-1:0]                   mr0,
  output logic [ADDR_W-1:0]                   mr1,
  output logic [ADDR_W-1:0]                   mr2,
  output logic [ADDR_W-1:0]                   mr3,
  output logic [4:0]                          cas_lat,
  output logic                                viol,
  output viol_t                               viol_code,
  output logic [15:0]                         viol_cnt
);

  localparam int NB = 2**BA_W;

  cmd_t          cmd;
  logic [NB-1:0] pre_mask;
  logic          bad_mrs;
  viol_t         proto_cause;
  viol_t         timing_cause;
  viol_t         cause;

  assign cmd      = decode_pins(cke, {cs_n, ras_n, cas_n, we_n});
  assign pre_mask = addr[10] ? {NB{1'b1}} : (NB'(1) << ba);
  // Any bank bit above the two that select mr0..mr3 makes the MRS illegal.
  assign bad_mrs  = (cmd == CMD_MRS) && (ba[BA_W-1:2] != '0);

  always_comb begin
    proto_cause = VIOL_NONE;
    case (cmd)
      CMD_ACT:         if (bank_open[ba])  proto_cause = VIOL_ACT_OPEN;
      CMD_RD, CMD_WR:  if (!bank_open[ba]) proto_cause = VIOL_RW_CLOSED;
      CMD_REF:         if (|bank_open)     proto_cause = VIOL_REF_OPEN;
      CMD_MRS:         if (bad_mrs)        proto_cause = VIOL_BAD_MRS;
      default:         proto_cause = VIOL_NONE;
    endcase
  end

`ifdef DDR3_TIMING_CHECK_EN
  localparam int RFC_W = $clog2(T_RFC + 1);

  logic [NB-1:0]    act_hit, pre_hit, rcd_busy, rp_busy, ras_busy;
  logic [RFC_W-1:0] rfc_cnt;

  assign act_hit = (cmd == CMD_ACT) ? (NB'(1) << ba) : '0;
  assign pre_hit = (cmd == CMD_PRE) ? pre_mask : '0;

  for (genvar i = 0; i < NB; i++) begin : g_bank
    ddr3_bank_timer #(
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .T_RAS (T_RAS)
    ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .act      (act_hit[i]),
      .pre      (pre_hit[i]),
      .rcd_busy (rcd_busy[i]),
      .rp_busy  (rp_busy[i]),
      .ras_busy (ras_busy[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rfc_cnt <= '0;
    else if (cmd == CMD_REF)  rfc_cnt <= RFC_W'(T_RFC - 1);
    else if (rfc_cnt != '0)   rfc_cnt <= rfc_cnt - RFC_W'(1);
  end

  always_comb begin
    timing_cause = VIOL_NONE;
    if (cmd != CMD_NOP && rfc_cnt != '0)
      timing_cause = VIOL_TRFC;
    else if (cmd == CMD_ACT && rp_busy[ba])
      timing_cause = VIOL_TRP;
    else if ((cmd == CMD_RD || cmd == CMD_WR) && rcd_busy[ba])
      timing_cause = VIOL_TRCD;
    else if (cmd == CMD_PRE && |(ras_busy & pre_mask))
      timing_cause = VIOL_TRAS;
  end
`else
  assign timing_cause = VIOL_NONE;
`endif

  assign cause = (timing_cause != VIOL_NONE) ? timing_cause : proto_cause;

  // Violating commands still update bank state; only a bad MRS is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
      bank_open <= '0;
      open_row  <= '0;
      mr0       <= '0;
      mr1       <= '0;
      mr2       <= '0;
      mr3       <= '0;
      cas_lat   <= '0;
      viol      <= 1'b0;
      viol_code <= VIOL_NONE;
      viol_cnt  <= '0;
    end else begin
      cmd_valid <= (cmd != CMD_NOP);
      viol      <= (cause != VIOL_NONE);
      if (cmd != CMD_NOP) begin
        cmd_type <= cmd;
        cmd_ba   <= ba;
        cmd_addr <= addr;
      end
      if (cause != VIOL_NONE) begin
        viol_code <= cause;
        if (viol_cnt != 16'hFFFF) viol_cnt <= viol_cnt + 16'd1;
      end
      case (cmd)
        CMD_ACT: begin
          bank_open[ba] <= 1'b1;
          open_row[ba]  <= addr;
        end
        CMD_PRE: bank_open <= bank_open & ~pre_mask;
        CMD_MRS: begin
          if (!bad_mrs) begin
            case (ba[1:0])
              2'd0: begin
                mr0     <= addr;
                cas_lat <= cl_decode(addr[2], addr[6:4]);
              end
              2'd1:    mr1 <= addr;
              2'd2:    mr2 <= addr;
              default: mr3 <= addr;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// Self-checking bench for ddr3_cmd_decoder: directed scenarios plus random traffic
// against a cycle-stamp reference model. Honours DDR3_TIMING_CHECK_EN like the RTL.
module tb_ddr3_cmd_decoder;
  import ddr3_dec_pkg::*;

  localparam int NB    = 8;
  localparam int T_RCD = 11;
  localparam int T_RP  = 11;
  localparam int T_RAS = 28;
  localparam int T_RFC = 128;
  localparam int NEVER = -1000000;

  localparam logic [3:0] P_MRS = 4'b0000, P_REF = 4'b0001, P_PRE = 4'b0010,
                         P_ACT = 4'b0011, P_WR  = 4'b0100, P_RD  = 4'b0101,
                         P_ZQ  = 4'b0110, P_NOP = 4'b0111;

  logic clk = 1'b0, rst = 1'b1, cke = 1'b1;
  logic cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0] ba = '0;
  logic [13:0] addr = '0;
  logic cmd_valid, viol;
  cmd_t cmd_type;
  viol_t viol_code;
  logic [2:0] cmd_ba;
  logic [13:0] cmd_addr, mr0, mr1, mr2, mr3;
  logic [7:0] bank_open;
  logic [7:0][13:0] open_row;
  logic [4:0] cas_lat;
  logic [15:0] viol_cnt;

  int checks = 0;
  int failures = 0;

  ddr3_cmd_decoder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .bank_open(bank_open), .open_row(open_row),
    .mr0(mr0), .mr1(mr1), .mr2(mr2), .mr3(mr3), .cas_lat(cas_lat), .viol(viol),
    .viol_code(viol_code), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: bank/mode state plus the cycle stamp of the last ACT/PRE/REF.
  int          cyc;
  bit          m_valid, m_viol;
  cmd_t        m_type;
  logic [2:0]  m_ba;
  logic [13:0] m_addr;
  bit          m_open[NB];
  logic [13:0] m_row[NB];
  logic [13:0] m_mr[4];
  int          m_cas;
  viol_t       m_code;
  int          m_cnt;
  int          last_act[NB], last_pre[NB], last_ref;

  function automatic cmd_t model_decode(input logic k, input logic [3:0] p);
    if (!k || p[3]) return CMD_NOP;
    case (p[2:0])
      3'b011:  return CMD_ACT;
      3'b101:  return CMD_RD;
      3'b100:  return CMD_WR;
      3'b010:  return CMD_PRE;
      3'b001:  return CMD_REF;
      3'b000:  return CMD_MRS;
      3'b110:  return CMD_ZQ;
      default: return CMD_NOP;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_viol = 0; m_type = CMD_NOP; m_ba = 0; m_addr = 0;
    m_cas = 0; m_code = VIOL_NONE; m_cnt = 0; last_ref = NEVER;
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 0; m_row[i] = 0; last_act[i] = NEVER; last_pre[i] = NEVER;
    end
    for (int i = 0; i < 4; i++) m_mr[i] = 0;
  endtask

  task automatic model_step();
    cmd_t  c;
    viol_t v;
    bit    any_open, tgt[NB];
    c = model_decode(cke, {cs_n, ras_n, cas_n, we_n});
    cyc++;
    v = VIOL_NONE;
    any_open = 0;
    for (int i = 0; i < NB; i++) begin
      any_open |= m_open[i];
      tgt[i] = addr[10] || (i == int'(ba));
    end
    if (c == CMD_ACT && m_open[ba]) v = VIOL_ACT_OPEN;
    if ((c == CMD_RD || c == CMD_WR) && !m_open[ba]) v = VIOL_RW_CLOSED;
    if (c == CMD_REF && any_open) v = VIOL_REF_OPEN;
    if (c == CMD_MRS && ba > 3) v = VIOL_BAD_MRS;
`ifdef DDR3_TIMING_CHECK_EN
    if (c == CMD_PRE)
      for (int i = 0; i < NB; i++)
        if (tgt[i] && cyc - last_act[i] < T_RAS) v = VIOL_TRAS;
    if ((c == CMD_RD || c == CMD_WR) && cyc - last_act[ba] < T_RCD) v = VIOL_TRCD;
    if (c == CMD_ACT && cyc - last_pre[ba] < T_RP) v = VIOL_TRP;
    if (c != CMD_NOP && cyc - last_ref < T_RFC) v = VIOL_TRFC;
`endif
    m_valid = (c != CMD_NOP);
    m_viol  = (v != VIOL_NONE);
    if (m_valid) begin m_type = c; m_ba = ba; m_addr = addr; end
    if (m_viol) begin
      m_code = v;
      if (m_cnt < 65535) m_cnt++;
    end
    case (c)
      CMD_ACT: begin m_open[ba] = 1; m_row[ba] = addr; last_act[ba] = cyc; end
      CMD_PRE: for (int i = 0; i < NB; i++) if (tgt[i]) begin m_open[i] = 0; last_pre[i] = cyc; end
      CMD_REF: last_ref = cyc;
      CMD_MRS: if (ba <= 3) begin
        m_mr[ba[1:0]] = addr;
        if (ba == 0) m_cas = addr[2] ? 0 : 4 + int'(addr[6:4]);
      end
      default: ;
    endcase
  endtask

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL cyc=%0d %s: got %0h expected %0h", cyc, name, got, exp);
    end
  endtask

  task automatic checkOutput();
    logic [7:0] eo;
    logic [7:0][13:0] er;
    for (int i = 0; i < NB; i++) begin eo[i] = m_open[i]; er[i] = m_row[i]; end
    cmp("cmd_valid", cmd_valid, m_valid);
    cmp("cmd_type", cmd_type, m_type);
    cmp("cmd_ba", cmd_ba, m_ba);
    cmp("cmd_addr", cmd_addr, m_addr);
    cmp("bank_open", bank_open, eo);
    cmp("open_row", open_row, er);
    cmp("mr0", mr0, m_mr[0]);
    cmp("mr1", mr1, m_mr[1]);
    cmp("mr2", mr2, m_mr[2]);
    cmp("mr3", mr3, m_mr[3]);
    cmp("cas_lat", cas_lat, m_cas);
    cmp("viol", viol, m_viol);
    cmp("viol_code", viol_code, m_code);
    cmp("viol_cnt", viol_cnt, m_cnt);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus(input logic k, input logic [3:0] p, input logic [2:0] b,
                               input logic [13:0] a);
    cke = k; {cs_n, ras_n, cas_n, we_n} = p; ba = b; addr = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, P_NOP, 3'd0, 14'd0);
  endtask

  task automatic mid_reset();
    {cs_n, ras_n, cas_n, we_n} = P_NOP;
    #2 rst = 1'b1;
    #1;
    model_reset();
    cmp("rst_cmd_valid", cmd_valid, 0);
    cmp("rst_bank_open", bank_open, 0);
    cmp("rst_viol_cnt", viol_cnt, 0);
    cmp("rst_mr0", mr0, 0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cyc = 0;
    model_reset();
    @(negedge clk);
    checkOutput();
    cmp("reset_viol_code", viol_code, VIOL_NONE);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1, P_MRS, 3'd0, 14'h0030);
    cmp("mrs_valid", cmd_valid, 1);
    cmp("mrs_mr0", mr0, 14'h0030);
    cmp("mrs_cas_lat", cas_lat, 7);
    idle(1);
    cmp("nop_valid", cmd_valid, 0);

    applyStimulus(1, P_ACT, 3'd2, 14'h1234);
    cmp("act_bank_open", bank_open, 8'h04);
    cmp("act_open_row2", open_row[2], 14'h1234);
    applyStimulus(1, P_ACT, 3'd2, 14'h0777);
    cmp("act2_viol", viol, 1);
    cmp("act2_code", viol_code, VIOL_ACT_OPEN);
    cmp("act2_cnt", viol_cnt, 1);

    applyStimulus(1, P_RD, 3'd5, 14'h0010);
    cmp("rd_closed_code", viol_code, VIOL_RW_CLOSED);

    applyStimulus(1, P_PRE, 3'd2, 14'h0000);
    applyStimulus(1, P_ACT, 3'd0, 14'h0100);
    applyStimulus(1, P_ACT, 3'd3, 14'h0300);
    cmp("two_open", bank_open, 8'h09);
    applyStimulus(1, P_PRE, 3'd0, 14'h0400);
    cmp("pre_all", bank_open, 8'h00);

    idle(40);
    applyStimulus(1, P_ACT, 3'd1, 14'h0011);
    idle(9);
    applyStimulus(1, P_RD, 3'd1, 14'h0000);
`ifdef DDR3_TIMING_CHECK_EN
    cmp("trcd10_viol", viol, 1);
    cmp("trcd10_code", viol_code, VIOL_TRCD);
`else
    cmp("trcd10_noviol", viol, 0);
`endif
    idle(30);
    applyStimulus(1, P_PRE, 3'd1, 14'h0000);
    idle(12);
    applyStimulus(1, P_ACT, 3'd1, 14'h0011);
    idle(10);
    applyStimulus(1, P_RD, 3'd1, 14'h0000);
    cmp("trcd11_noviol", viol, 0);

    applyStimulus(1, P_PRE, 3'd0, 14'h0400);
    idle(140);
    applyStimulus(1, P_REF, 3'd0, 14'h0000);
    cmp("ref_noviol", viol, 0);
    idle(49);
    applyStimulus(1, P_ACT, 3'd4, 14'h0044);
`ifdef DDR3_TIMING_CHECK_EN
    cmp("trfc_code", viol_code, VIOL_TRFC);
    cmp("trfc_viol", viol, 1);
`else
    cmp("trfc_noviol", viol, 0);
`endif

    applyStimulus(1, P_REF, 3'd0, 14'h0000);
    idle(3);
    mid_reset();
    applyStimulus(1, P_ACT, 3'd6, 14'h0066);
    cmp("post_rst_viol", viol, 0);
    cmp("post_rst_open", bank_open, 8'h40);

    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [3:0] p;
      r = $urandom_range(0, 99);
      if (r < 35)      p = P_NOP;
      else if (r < 37) p = 4'b1000 | 4'($urandom_range(0, 7));
      else if (r < 52) p = P_ACT;
      else if (r < 64) p = P_RD;
      else if (r < 74) p = P_WR;
      else if (r < 86) p = P_PRE;
      else if (r < 88) p = P_REF;
      else if (r < 94) p = P_MRS;
      else             p = P_ZQ;
      if ($urandom_range(0, 599) == 0) mid_reset();
      applyStimulus($urandom_range(0, 9) != 0, p, 3'($urandom_range(0, 7)), 14'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
